// File: rtl/riscv_pkg.sv
// Definitions shared by the execute-stage units: divider op codes, divider FSM
// states, ALU-compatible flag bit positions and the fixed divider latency.
package riscv_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int DIV_LATENCY = 34;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the
// divisor magnitude and keep the difference when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH+1:0] w_trial;

    assign w_rem_sh = {i_rem, i_quo[WIDTH-1]};
    // Extra headroom bit makes the sign of the trial difference unambiguous.
    assign w_trial  = {1'b0, w_rem_sh} - {2'b00, i_div};

    always_comb begin
        o_quo = {i_quo[WIDTH-2:0], ~w_trial[WIDTH+1]};
        o_rem = w_trial[WIDTH+1] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: magnitude restoring divider, one quotient bit
// per cycle, followed by a sign/special-case fix cycle and a one-cycle done.
module div_unit
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [4:0]       LAST_IT  = 5'(WIDTH - 1);

    div_state_e       r_state;
    logic [4:0]       r_cnt;
    logic [WIDTH-1:0] r_rem, r_quo, r_div, r_a;
    logic             r_is_rem, r_neg_q, r_neg_r, r_div0, r_ovf;
    logic             r_busy, r_done;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;

    logic             w_accept, w_signed;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic [WIDTH-1:0] w_rem_next, w_quo_next;
    logic [WIDTH-1:0] w_quo_fix, w_rem_fix, w_res_fix;
    logic [3:0]       w_flags_fix;

    assign w_accept = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_signed = ~op[0];
    assign w_a_mag  = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_b_mag  = (w_signed && b[WIDTH-1]) ? -b : b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_next),
        .o_quo (w_quo_next)
    );

    // Special cases override the magnitude result; the iterations still run.
    always_comb begin
        w_quo_fix = r_neg_q ? -r_quo : r_quo;
        w_rem_fix = r_neg_r ? -r_rem : r_rem;
        if (r_div0) begin
            w_quo_fix = '1;
            w_rem_fix = r_a;
        end else if (r_ovf) begin
            w_quo_fix = MOST_NEG;
            w_rem_fix = '0;
        end
        w_res_fix           = r_is_rem ? w_rem_fix : w_quo_fix;
        w_flags_fix         = 4'b0000;
        w_flags_fix[FLAG_N] = w_res_fix[WIDTH-1];
        w_flags_fix[FLAG_Z] = (w_res_fix == '0);
        w_flags_fix[FLAG_C] = 1'b0;
        w_flags_fix[FLAG_V] = r_ovf && !r_is_rem;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_a      <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_state  <= ST_CALC;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_rem    <= '0;
                        r_quo    <= w_a_mag;
                        r_div    <= w_b_mag;
                        r_a      <= a;
                        r_is_rem <= op[1];
                        r_neg_q  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r  <= w_signed && a[WIDTH-1];
                        r_div0   <= (b == '0);
                        r_ovf    <= w_signed && (a == MOST_NEG) && (b == '1);
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == LAST_IT) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_result <= w_res_fix;
                    r_flags  <= w_flags_fix;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign flags  = r_flags;

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle RV32M divide/remainder unit for the RISC-V core: consumes two 32-bit operands plus an M-extension op selector and returns quotient or remainder with the same `{N,Z,C,V}` flag packing the ALU produces. It sits beside the ALU in the execute stage. A start/busy/done handshake lets the control path stall the core while the unit is busy. The unit is a restoring divider that resolves one quotient bit per cycle, with a fixed, data-independent latency.

## Interface
- `WIDTH`, default 32: operand and result width; only 32 is supported.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `op`  in  2  operation select, equal to funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `a`  in  32  dividend; captured on an accepted start.
- `b`  in  32  divisor; captured on an accepted start.
- `busy`  out  1  high in CALC and FIX.
- `done`  out  1  one-cycle pulse (state DONE); `result` and `flags` are valid from this cycle.
- `result`  out  32  quotient or remainder; registered and held until the next done.
- `flags`  out  4  `{Negative, Zero, Carry, Overflow}`, registered together with `result`.

## Operation
- States:
  - IDLE: waits for a request.
  - CALC: 32 iterations.
  - FIX: sign correction and special cases.
  - DONE: one cycle, then returns to IDLE.
- Start acceptance:
  - `start` is accepted in IDLE or DONE. An accept in DONE gives back-to-back operation.
  - `start` is ignored in CALC and FIX.
- On accept, latch `op`, `a`, `b`, and sign bits.
  - Signed ops (DIV, REM) convert operands to magnitudes.
  - Clear the remainder register and iteration counter.
- CALC iteration (one per cycle):
  - Shift `{rem, quo}` left by 1.
  - Compute trial = rem − |b| as a 33-bit subtract.
  - If trial ≥ 0: rem = trial and quotient LSB = 1. Otherwise the quotient LSB is 0.
  - The counter runs 0..31, then the state moves to FIX.
- FIX, normal case:
  - Quotient is negated if signed and sign(a) ≠ sign(b).
  - Remainder is negated if signed and `a` is negative.
- FIX, divide by zero (`b` = 0, all ops):
  - Quotient = 0xFFFFFFFF.
  - Remainder = `a`, unmodified.
- FIX, signed overflow (DIV/REM with `a` = 0x80000000 and `b` = 0xFFFFFFFF):
  - Quotient = 0x80000000.
  - Remainder = 0.
- Special cases still take the full latency; there is no early-out.
- `flags`:
  - N = `result[31]`.
  - Z = (`result` == 0).
  - C = 0 always.
  - V = 1 only for signed overflow on DIV. V is 0 for REM and for all other cases, including divide by zero.
- Reset, including mid-operation: next state is IDLE. `busy` = 0, `done` = 0, `result` = 0, `flags` = 4'b0000. Latched operands are don't-care.

## Timing
- Accepted start at edge 0:
  - Cycles 1–32 are CALC, with iterations at edges 1–32.
  - Cycle 33 is FIX.
  - Edge 33 registers `result` and `flags`.
  - Cycle 34 is DONE: `done` = 1, `busy` = 0.
- Latency is 34 cycles from start to done, for every op and operand value.
- `busy` is high in cycles 1–33; `busy` and `done` are never high together.
- `result`/`flags` change only at the edge entering DONE, or on reset.
- A start accepted in DONE at edge 34 produces its own done at cycle 68.
- The `a`, `b`, `op` inputs may change freely after acceptance without effect.

## Structure
- Shared package `riscv_pkg` holds:
  - op encodings: `DIV_OP_DIV`, `DIV_OP_DIVU`, `DIV_OP_REM`, `DIV_OP_REMU`;
  - the state enum (IDLE, CALC, FIX, DONE);
  - flag bit indices (N = 3, Z = 2, C = 1, V = 0), shared with the ALU;
  - `DIV_LATENCY` = 34.
- One sub-module, `div_step`:
  - combinational single restoring iteration;
  - inputs: rem, quo, divisor magnitude;
  - outputs: next rem, next quo.
- Counter, FSM, and sign fix live in `div_unit`.

## Test plan
- DIVU `a`=100, `b`=7 at cycle 0 -> `busy` high in cycles 1–33; `done` in cycle 34 with `result`=14, `flags`=0000. REMU on the same operands -> 2.
- DIV `a`=−20 (0xFFFFFFEC), `b`=3 -> `result`=0xFFFFFFFA (−6), N=1. REM on the same operands -> 0xFFFFFFFE (−2), N=1.
- DIVU 5/0 -> 0xFFFFFFFF, N=1, V=0. REM 5/0 -> 5. DIV 0/0 -> 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, flags=1001. REM on the same operands -> 0, flags=0100.
- Start asserted continuously, with new operands in cycles 1–33 -> those starts are ignored and the first result is unchanged. The start held in cycle 34 is accepted, giving done at cycle 68.
- `reset` in cycle 10 of an operation -> cycle 11 has `busy`=0, `done`=0, `result`=0, `flags`=0. A fresh start afterwards completes correctly after 34 cycles.
